// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, status/cause bit positions
// and the exception sequencer state encoding.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    localparam int SR_IE_BIT = 0;
    localparam int IM_LSB    = 8;
    localparam int IP_LSB    = 8;
    localparam int EXC_LSB   = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENTER  = 2'd1,
        ST_HANDLE = 2'd2,
        ST_RETURN = 2'd3
    } cp0_state_e;

endpackage

// File: rtl/cp0_exc_ctrl_prio.sv
// Fixed-priority encoder: index of the lowest set request bit (bit 0 = highest priority).
module cp0_prio_enc #(
    parameter int N  = 7,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt sequencer: SR/Cause/EPC, IRQ arbitration, fetch redirect.
// Optional timer (Count/Compare) enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter int          NIRQ         = 6,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NIRQ-1:0]               irq,
    input  logic                          commit,
    input  logic [31:0]                   next_pc,
    input  logic                          sys,
    input  logic                          exce_ret,
    input  logic                          mtc0,
    input  logic [4:0]                    cp0_addr,
    input  logic [31:0]                   cp0_wdata,
    output logic [31:0]                   cp0_rdata,
    output logic                          redir_valid,
    input  logic                          redir_ready,
    output logic [31:0]                   redir_pc,
    output logic                          in_handler,
    output cp0_state_e                    dbg_state,
    output logic [$clog2(NIRQ+1)-1:0]     dbg_src
);

    localparam int SRC_W = $clog2(NIRQ + 1);

    cp0_state_e        state, state_nx;
    logic              sr_ie;
    logic [NIRQ:0]     sr_im;
    logic [NIRQ-1:0]   irq_q;
    logic [4:0]        exc_code;
    logic [31:0]       epc;
    logic [31:0]       count;
    logic [31:0]       compare;
    logic              timer_pend;
    logic [NIRQ:0]     ip;
    logic [NIRQ:0]     pend;
    logic              irq_take;
    logic              take_sys, take_irq, ret_done;
    logic              mtc0_ok;
    logic [SRC_W-1:0]  enc_idx;
    logic              enc_valid;

    // Timer pending occupies the top IP slot so it is the lowest-priority source.
    assign ip       = {timer_pend, irq_q};
    assign pend     = ip & sr_im;
    assign irq_take = sr_ie & (|pend);
    assign mtc0_ok  = commit & mtc0 & (state != ST_ENTER) & (state != ST_RETURN);
    assign dbg_state = state;

    cp0_prio_enc #(.N(NIRQ + 1), .IW(SRC_W)) u_prio (
        .req   (pend),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_nx    = state;
        redir_valid = 1'b0;
        redir_pc    = '0;
        in_handler  = 1'b0;
        take_sys    = 1'b0;
        take_irq    = 1'b0;
        ret_done    = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (commit && sys)           take_sys = 1'b1;
                else if (commit && irq_take) take_irq = 1'b1;
                if (take_sys || take_irq)    state_nx = ST_ENTER;
            end
            ST_ENTER: begin
                redir_valid = 1'b1;
                redir_pc    = HANDLER_ADDR;
                in_handler  = 1'b1;
                if (redir_ready) state_nx = ST_HANDLE;
            end
            ST_HANDLE: begin
                in_handler = 1'b1;
                if (commit && exce_ret) state_nx = ST_RETURN;
            end
            ST_RETURN: begin
                redir_valid = 1'b1;
                redir_pc    = epc;
                in_handler  = 1'b1;
                if (redir_ready) begin
                    state_nx = ST_RUN;
                    ret_done = 1'b1;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            sr_ie    <= 1'b0;
            sr_im    <= '0;
            irq_q    <= '0;
            exc_code <= '0;
            epc      <= '0;
            dbg_src  <= '0;
        end else begin
            state <= state_nx;
            irq_q <= irq;
            if (mtc0_ok && cp0_addr == CP0_SR) begin
                sr_ie <= cp0_wdata[SR_IE_BIT];
                sr_im <= cp0_wdata[IM_LSB +: NIRQ+1];
            end
            if (mtc0_ok && cp0_addr == CP0_EPC) epc <= cp0_wdata;
            // Exception entry overrides a coincident MTC0 to IE or EPC.
            if (take_sys || take_irq) begin
                sr_ie    <= 1'b0;
                epc      <= next_pc;
                exc_code <= take_sys ? EXC_SYS : EXC_INT;
            end
            if (take_irq && enc_valid) dbg_src <= enc_idx;
            if (ret_done) sr_ie <= 1'b1;
        end
    end

`ifdef CP0_TIMER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            count <= count + 32'd1;
            if (mtc0_ok && cp0_addr == CP0_COMPARE) begin
                compare    <= cp0_wdata;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end
`else
    assign count      = '0;
    assign compare    = '0;
    assign timer_pend = 1'b0;
`endif

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:      cp0_rdata = {{(23-NIRQ){1'b0}}, sr_im, 7'b0, sr_ie};
            CP0_CAUSE:   cp0_rdata = {{(23-NIRQ){1'b0}}, ip, 1'b0, exc_code, 2'b0};
            CP0_EPC:     cp0_rdata = epc;
            CP0_COUNT:   cp0_rdata = count;
            CP0_COMPARE: cp0_rdata = compare;
            default:     cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized traffic
// against a register-level reference model and a redirect-target queue.
module tb_cp0_exc_ctrl;
    import cp0_exc_ctrl_pkg::*;

    localparam int          NIRQ  = 6;
    localparam logic [31:0] HADDR = 32'h0000_4180;
    localparam logic [31:0] SR_MASK = ((32'h1 << (NIRQ + 1)) - 32'h1) << 8 | 32'h1;
    localparam int M_RUN = 0, M_ENTER = 1, M_HANDLE = 2, M_RETURN = 3;

    logic              clk, rst_n;
    logic [NIRQ-1:0]   irq;
    logic              commit, sys, exce_ret, mtc0, redir_ready;
    logic [31:0]       next_pc, cp0_wdata, cp0_rdata, redir_pc;
    logic [4:0]        cp0_addr;
    logic              redir_valid, in_handler;
    cp0_state_e        dbg_state;
    logic [2:0]        dbg_src;

    cp0_exc_ctrl #(.NIRQ(NIRQ), .HANDLER_ADDR(HADDR)) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .commit(commit), .next_pc(next_pc),
        .sys(sys), .exce_ret(exce_ret), .mtc0(mtc0), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .redir_valid(redir_valid),
        .redir_ready(redir_ready), .redir_pc(redir_pc), .in_handler(in_handler),
        .dbg_state(dbg_state), .dbg_src(dbg_src)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    int              m_mode;
    logic [31:0]     m_sr, m_epc, m_count, m_compare;
    logic [4:0]      m_exc;
    logic [NIRQ-1:0] m_irq_prev;
    logic            m_tpend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return (32'({m_tpend, m_irq_prev}) << 8) | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_sr = 0; m_epc = 0; m_count = 0; m_compare = 0;
        m_exc = 0; m_irq_prev = 0; m_tpend = 0;
        exp_q.delete();
    endtask

    // Applies one clock edge of architectural behaviour using the inputs present at that edge.
    task automatic model_update();
        logic [31:0] pending;
        logic        take, wr_ok;
        logic [31:0] old_count, old_compare;
        pending     = (32'({m_tpend, m_irq_prev}) << 8) & m_sr;
        take        = m_sr[0] && (pending != 0);
        wr_ok       = commit && mtc0 && m_mode != M_ENTER && m_mode != M_RETURN;
        old_count   = m_count;
        old_compare = m_compare;
        if (wr_ok && cp0_addr == 5'd12) m_sr = cp0_wdata & SR_MASK;
        if (wr_ok && cp0_addr == 5'd14) m_epc = cp0_wdata;
`ifdef CP0_TIMER_EN
        m_count = old_count + 1;
        if (wr_ok && cp0_addr == 5'd11) begin
            m_compare = cp0_wdata;
            m_tpend   = 1'b0;
        end else if (old_count == old_compare) begin
            m_tpend = 1'b1;
        end
`endif
        case (m_mode)
            M_RUN: if (commit && (sys || take)) begin
                m_exc  = sys ? 5'd8 : 5'd0;
                m_epc  = next_pc;
                m_sr[0] = 1'b0;
                m_mode = M_ENTER;
                exp_q.push_back(HADDR);
            end
            M_ENTER: if (redir_ready) m_mode = M_HANDLE;
            M_HANDLE: if (commit && exce_ret) begin
                m_mode = M_RETURN;
                exp_q.push_back(m_epc);
            end
            default: if (redir_ready) begin
                m_mode = M_RUN;
                m_sr[0] = 1'b1;
            end
        endcase
        m_irq_prev = irq;
    endtask

    task automatic compare_all();
        logic redirecting;
        redirecting = (m_mode == M_ENTER) || (m_mode == M_RETURN);
        check("redir_valid", 32'(redir_valid), 32'(redirecting));
        check("in_handler", 32'(in_handler), 32'(m_mode != M_RUN));
        if (redirecting) check("redir_pc", redir_pc, exp_q.size() > 0 ? exp_q[0] : 32'hDEAD_BEEF);
        else             check("redir_pc_idle", redir_pc, 32'h0);
        check("cp0_rdata", cp0_rdata, m_read(cp0_addr));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        if (redir_valid && redir_ready) begin
            if (exp_q.size() == 0) check("redir_spurious", 32'h1, 32'h0);
            else                   check("redir_target", redir_pc, exp_q.pop_front());
        end
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle();
        commit = 0; sys = 0; exce_ret = 0; mtc0 = 0;
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); commit = 1; mtc0 = 1; cp0_addr = a; cp0_wdata = d;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle(); irq = '0; redir_ready = 0;
        rst_n = 0;
        #2;
        model_reset();
        check("rst_redir_valid", 32'(redir_valid), 32'h0);
        check("rst_redir_pc", redir_pc, 32'h0);
        check("rst_in_handler", 32'(in_handler), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_RUN));
        check("rst_rdata", cp0_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] addr_tab[7];

    initial begin
        addr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3};
        rst_n = 0; irq = '0; idle(); next_pc = 0; cp0_addr = 5'd12; cp0_wdata = 0; redir_ready = 0;
        do_reset();
        peek("rst_sr", 5'd12, 32'h0);
        peek("rst_cause", 5'd13, 32'h0);
        peek("rst_epc", 5'd14, 32'h0);
        tick();

        // Interrupt entry with a held-off redirect.
        do_mtc0(5'd12, 32'h0000_0101);
        irq = 6'h01;
        tick();
        commit = 1; next_pc = 32'h40;
        tick();
        idle();
        check("int_redir_valid", 32'(redir_valid), 32'h1);
        check("int_redir_pc", redir_pc, HADDR);
        check("int_src", 32'(dbg_src), 32'h0);
        peek("int_epc", 5'd14, 32'h40);
        peek("int_cause", 5'd13, 32'h0000_0100);
        peek("int_sr_ie0", 5'd12, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("int_hold_valid", 32'(redir_valid), 32'h1);
        end
        redir_ready = 1; tick(); redir_ready = 0;

        // In the handler: sys and a live irq must not redirect.
        commit = 1; sys = 1; tick(); idle(); tick();
        check("handle_no_redir", 32'(redir_valid), 32'h0);
        check("handle_in_handler", 32'(in_handler), 32'h1);
        commit = 1; exce_ret = 1; tick(); idle();
        check("eret_redir_pc", redir_pc, 32'h40);
        redir_ready = 1; tick(); redir_ready = 0;
        peek("eret_sr_ie1", 5'd12, 32'h0000_0101);
        irq = '0; tick(); tick();

        // sys and irq on the same commit: sys wins, single entry.
        irq = 6'h01; tick();
        commit = 1; sys = 1; next_pc = 32'h80; tick(); idle();
        peek("sys_cause", 5'd13, 32'h0000_0120);
        redir_ready = 1; tick(); redir_ready = 0;
        tick(); tick();
        check("sys_single_entry", 32'(redir_valid), 32'h0);
        commit = 1; exce_ret = 1; irq = '0; tick(); idle();
        redir_ready = 1; tick(); redir_ready = 0; tick();

        // Reset while redirecting to the handler.
        commit = 1; sys = 1; tick(); idle();
        check("enter_before_rst", 32'(redir_valid), 32'h1);
        do_reset();
        tick();

        // Interrupts enabled but all masked.
        do_mtc0(5'd12, 32'h0000_0001);
        irq = 6'h3F; tick();
        for (int i = 0; i < 3; i++) begin
            commit = 1; next_pc = 32'(i) << 2; tick();
        end
        idle();
        check("masked_no_entry", 32'(in_handler), 32'h0);
        peek("masked_ip", 5'd13, m_read(5'd13));
        check("masked_ip_bits", (cp0_rdata >> 8) & 32'h3F, 32'h3F);
        irq = '0;

        // Timer: Compare=20 with the timer mask bit set.
        do_reset();
        do_mtc0(5'd11, 32'd20);
        do_mtc0(5'd12, 32'h1 | (32'h1 << (8 + NIRQ)));
        for (int i = 0; i < 40; i++) begin
            commit = (m_mode == M_RUN); next_pc = 32'h100 + 32'(i); tick();
        end
        idle();
`ifdef CP0_TIMER_EN
        check("timer_entry", 32'(in_handler), 32'h1);
        redir_ready = 1; tick(); redir_ready = 0;
        do_mtc0(5'd11, 32'd5000);
        peek("timer_pend_clr", 5'd13, 32'h0);
        commit = 1; exce_ret = 1; tick(); idle();
        redir_ready = 1; tick(); redir_ready = 0;
`else
        check("timer_never", 32'(in_handler), 32'h0);
        peek("timer_count_zero", 5'd9, 32'h0);
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) irq = NIRQ'($urandom);
            commit   = $urandom_range(0, 1) == 1;
            sys      = $urandom_range(0, 15) == 0;
            exce_ret = $urandom_range(0, 5) == 0;
            mtc0     = $urandom_range(0, 7) == 0;
            cp0_addr = addr_tab[$urandom_range(0, 6)];
            cp0_wdata = (cp0_addr == 5'd11) ? m_count + 32'($urandom_range(1, 40)) : $urandom;
            next_pc  = $urandom & 32'hFFFF_FFFC;
            redir_ready = $urandom_range(0, 2) == 0;
            tick();
        end
        idle(); redir_ready = 1;
        for (int i = 0; i < 4; i++) begin
            commit = (m_mode == M_HANDLE); exce_ret = 1; tick();
        end
        idle(); redir_ready = 0;
        check("q_consistent", 32'(exp_q.size()),
              (m_mode == M_ENTER || m_mode == M_RETURN) ? 32'h1 : 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
